weighted_rr_arbiter: RTL and testbench
======================================

WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, legal range 1..16.
REQ-002 Parameter CW, default 4: width of each per-requester weight field.
REQ-003 Parameter IW, default $clog2(N) with a minimum of 1: width of gnt_id.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  N  request vector; bit i is requester i and is level-sensitive.
REQ-007 weight  input  N*CW  per-requester burst weight; field i is bits [i*CW +: CW].
REQ-008 en  input  1  arbitration enable; low freezes all state and outputs.
REQ-009 gnt  output  N  registered one-hot grant, or all zeros.
REQ-010 gnt_id  output  IW  registered binary index of the current owner.
REQ-011 gnt_valid  output  1  registered; high exactly when gnt is nonzero.

Function
REQ-012 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner k holds the grant).
REQ-013 Round-robin pointer ptr SHALL hold the index of the last granted requester.
REQ-014 pick(s) SHALL return the first asserted req bit, searching cyclically s, s+1, ..., s+N-1 mod N; it returns none if req is all zeros.
REQ-015 IDLE with any req high: next edge SHALL enter BUSY with owner = pick(ptr+1); gnt/gnt_id/gnt_valid update on that edge, one-cycle latency from req.
REQ-016 On grant start, the block SHALL latch quantum = weight[owner] and clear burst counter cnt to 0.
REQ-017 BUSY, req[k]=1, cnt<quantum: the grant SHALL be held and cnt incremented, so a burst lasts quantum+1 cycles.
REQ-018 BUSY, req[k]=1, cnt==quantum: the block SHALL rotate to pick(k+1) on the next edge, with no idle bubble.
REQ-019 If pick(k+1) in REQ-018 returns k because k is the sole requester, k SHALL be re-granted with a freshly latched quantum and cnt=0.
REQ-020 BUSY, req[k]=0: the grant SHALL move to pick(k+1) on the next edge, or go to IDLE with all outputs zero if none; the remaining burst is forfeited.
REQ-021 ptr SHALL be updated to the owner index on every grant start and is never changed on release to IDLE.
REQ-022 Weight changes mid-burst SHALL have no effect until the next grant start.
REQ-023 Weight 0 SHALL give single-cycle bursts; the maximum weight 2^CW-1 gives 2^CW cycles; cnt is CW bits and never wraps.
REQ-024 en=0 SHALL hold state, ptr, cnt and outputs unchanged regardless of req; on re-enable, evaluation resumes from the held state.
REQ-025 When N=1, the block SHALL behave as a burst-limited pass-through with gnt_id=0.
REQ-026 gnt SHALL never have more than one bit set, and gnt_id SHALL be 0 whenever gnt_valid=0.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, gnt=0, gnt_id=0, gnt_valid=0, cnt=0 and ptr=N-1, so requester 0 has top priority after reset.
REQ-028 rst SHALL take precedence over en and req, and SHALL abort any burst in progress immediately.

Structure
REQ-029 Shared package arb_pkg SHALL hold the state encoding constants (IDLE=0, BUSY=1) and the IW computation.
REQ-030 The cyclic priority encoder SHALL be a purely combinational sub-module rr_pick with parameter N and ports req, start, idx and found.
REQ-031 All outputs SHALL be driven directly from flops, with no combinational path from req to gnt.

Verification
REQ-032 N=4, weights all 0, req=1111 held from reset release: gnt sequence SHALL be 0001, 0010, 0100, 1000, 0001, ..., one per cycle.
REQ-033 N=4, weight[0]=2, weight[1]=0, req=0011: gnt SHALL be 0001 for 3 cycles, then 0010 for 1 cycle, then repeat.
REQ-034 Owner 2 with quantum 5 drops req[2] after 2 cycles while req=1001: gnt SHALL go to 1000 on the next edge, and ptr SHALL become 3.
REQ-035 Only req[1] high, weight[1]=1: gnt SHALL stay 0010 continuously with the burst counter reloading every 2 cycles; req falling to 0000 gives gnt=0000 next edge.
REQ-036 en pulled low mid-burst for 4 cycles with req changing: outputs SHALL be frozen, and the burst SHALL complete its remaining cycles after en returns high.
REQ-037 rst asserted mid-burst with req=1111: all outputs SHALL be 0 next edge, and the first grant after release SHALL be 0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM state
// encoding and the index-width rule used for requester indices.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int arb_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first asserted req bit searching start, start+1, ...
// modulo N. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [arb_iw(N)-1:0]  start,
    output logic [arb_iw(N)-1:0]  idx,
    output logic                  found
);

    localparam int PW = arb_iw(N);

    always_comb begin
        int unsigned c;
        logic [PW-1:0] ci;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c  = (32'(start) + i) % N;
            ci = PW'(c);
            if (!found && req[ci]) begin
                found = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each grant is a burst of weight+1 cycles,
// then ownership rotates cyclically past the current owner.
module weighted_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 4,
    parameter int IW = arb_iw(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] weight,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_valid
);

    localparam int PW = arb_iw(N);

    state_t        state_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_id_q;
    logic          gnt_valid_q;
    logic [PW-1:0] owner_q;
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] quantum_q;

    logic [CW-1:0] wt [N];
    logic [PW-1:0] base;
    logic [PW-1:0] start;
    logic [PW-1:0] pick_idx;
    logic          pick_found;

    for (genvar g = 0; g < N; g++) begin : g_wt
        assign wt[g] = weight[g*CW +: CW];
    end

    // Search starts one past the owner when busy, one past the last grant when idle.
    always_comb begin
        base  = (state_q == BUSY) ? owner_q : ptr_q;
        start = (base == PW'(N-1)) ? '0 : base + PW'(1);
    end

    rr_pick #(
        .N(N)
    ) u_pick (
        .req  (req),
        .start(start),
        .idx  (pick_idx),
        .found(pick_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= PW'(N-1);
            cnt_q       <= '0;
            quantum_q   <= '0;
        end else if (en) begin
            if (state_q == BUSY && req[owner_q] && cnt_q < quantum_q) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pick_found) begin
                // Covers new grants, rotation at burst end and sole-requester re-grant.
                state_q     <= BUSY;
                owner_q     <= pick_idx;
                ptr_q       <= pick_idx;
                gnt_q       <= N'(1) << pick_idx;
                gnt_id_q    <= IW'(pick_idx);
                gnt_valid_q <= 1'b1;
                quantum_q   <= wt[pick_idx];
                cnt_q       <= '0;
            end else begin
                state_q     <= IDLE;
                owner_q     <= '0;
                gnt_q       <= '0;
                gnt_id_q    <= '0;
                gnt_valid_q <= 1'b0;
                cnt_q       <= '0;
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter (N=4, CW=4) with hand-computed grants.
module tb_weighted_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] weight;
    logic        en;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    weighted_rr_arbiter #(
        .N (4),
        .CW(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .weight   (weight),
        .en       (en),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setw(input int i, input logic [3:0] v);
        weight[i*4 +: 4] = v;
    endtask

    task automatic chk(input string tag, input logic [3:0] g);
        logic [1:0] id;
        logic       v;
        id = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) id = 2'(i);
        v = |g;
        total++;
        assert (gnt === g) passed++;
        else $error("FAIL %s gnt got=%b exp=%b", tag, gnt, g);
        total++;
        assert (gnt_id === id) passed++;
        else $error("FAIL %s gnt_id got=%0d exp=%0d", tag, gnt_id, id);
        total++;
        assert (gnt_valid === v) passed++;
        else $error("FAIL %s gnt_valid got=%b exp=%b", tag, gnt_valid, v);
    endtask

    task automatic tick_chk(input string tag, input logic [3:0] g);
        tick();
        chk(tag, g);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 4'b0000; weight = '0;
        tick();
        tick_chk("reset", 4'b0000);

        // All requesting, zero weights: one grant per cycle in order
        rst = 1'b0; req = 4'b1111;
        tick_chk("rr0", 4'b0001);
        tick_chk("rr1", 4'b0010);
        tick_chk("rr2", 4'b0100);
        tick_chk("rr3", 4'b1000);
        tick_chk("rr4", 4'b0001);
        tick_chk("rr5", 4'b0010);

        // weight[0]=2, weight[1]=0, req=0011: 3 cycles owner 0, 1 cycle owner 1
        setw(0, 4'd2); req = 4'b0011;
        tick_chk("w0a", 4'b0001);
        tick_chk("w0b", 4'b0001);
        tick_chk("w0c", 4'b0001);
        tick_chk("w1",  4'b0010);
        tick_chk("w0d", 4'b0001);
        tick_chk("w0e", 4'b0001);
        tick_chk("w0f", 4'b0001);
        tick_chk("w1b", 4'b0010);

        // Sole requester 1 with weight 1 keeps the grant across re-grants
        setw(1, 4'd1); req = 4'b0010;
        for (int i = 0; i < 5; i++) tick_chk("sole", 4'b0010);
        req = 4'b0000;
        tick_chk("release", 4'b0000);
        tick_chk("idle", 4'b0000);

        // Owner 2 (quantum 5) drops its request after 2 cycles
        setw(2, 4'd5); setw(3, 4'd0); req = 4'b0100;
        tick_chk("own2a", 4'b0100);
        tick_chk("own2b", 4'b0100);
        req = 4'b1001;
        tick_chk("drop", 4'b1000);
        total++;
        assert (dut.ptr_q === 2'd3) passed++;
        else $error("FAIL ptr got=%0d exp=3", dut.ptr_q);
        tick_chk("rot0", 4'b0001);

        // Freeze mid-burst: owner 0, quantum 2, already used 1 cycle
        tick_chk("burst1", 4'b0001);
        en = 1'b0; setw(0, 4'd0);
        req = 4'b0110; tick_chk("frz0", 4'b0001);
        req = 4'b0000; tick_chk("frz1", 4'b0001);
        req = 4'b1111; tick_chk("frz2", 4'b0001);
        req = 4'b0010; tick_chk("frz3", 4'b0001);
        en = 1'b1; req = 4'b1001;
        tick_chk("resume", 4'b0001);
        tick_chk("after", 4'b1000);

        // Reset aborts a burst, overriding en and req
        setw(0, 4'd3); req = 4'b1111;
        tick_chk("pre_rst0", 4'b0001);
        tick_chk("pre_rst1", 4'b0001);
        rst = 1'b1;
        tick_chk("rst_abort", 4'b0000);
        en = 1'b0;
        tick_chk("rst_over_en", 4'b0000);

        // Maximum weight: 16-cycle burst, then rotation
        rst = 1'b0; en = 1'b1; setw(0, 4'd15);
        for (int i = 0; i < 16; i++) tick_chk("maxw", 4'b0001);
        tick_chk("maxw_end", 4'b0010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
